host_pin_responder: RTL and testbench
=====================================

# host_pin_responder

Register-file responder behind the top-level pin interface: the on-chip end of the host transactions the bench (or board MCU) drives onto `ui_in`/`uio_in`. It accepts read/write commands with a four-phase req/ack handshake and returns read data on the bidirectional pins. It holds seven general registers plus a read-only transaction counter. It is instantiated inside the top-level user module and directly owns `uo_out`, `uio_out` and `uio_oe`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: depth of the `req` synchronizer (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `ena`  in  1  design selected; when 0, no new transaction starts.
- `ui_in`  in  8  `[7]` req, `[6]` we (1 = write), `[5:3]` reserved (ignored), `[2:0]` addr.
- `uio_in`  in  8  write data.
- `uo_out`  out  8  `[7]` ack, `[6:4]` last addr, `[3:0]` counter[3:0].
- `uio_out`  out  8  read data; 0x00 when not acking a read.
- `uio_oe`  out  8  0xFF while acking a read, else 0x00.

## Operation
- Reset values: all outputs 0, regs[0..6] = 0x00, counter = 0x00, FSM in IDLE, synchronizer cleared.
- `req` passes through a `SYNC_STAGES` synchronizer, giving `req_s`. All other inputs are sampled unsynchronized. The host holds them stable from req rise until ack rise.
- FSM states: IDLE, EXEC, ACK.
  - IDLE → EXEC when `req_s`=1 and `ena`=1. On this edge, capture we, addr and data.
  - EXEC → ACK always. This state is committed: a `req` drop here is ignored. On this edge:
    - A write to addr 0–6 updates the register.
    - A write to addr 7 is discarded.
    - A read loads `rdata` from the register, or from the counter for addr 7.
    - The counter increments (8-bit, wraps 0xFF→0x00).
    - `uo_out[6:4]` takes addr.
  - ACK → IDLE when `req_s`=0. Otherwise stay in ACK.
- Outputs in ACK: ack=1. For a read, `uio_out`=`rdata` and `uio_oe`=0xFF. For a write, both are 0x00.
- Ack drops on the edge that leaves ACK. `uio_oe` returns to 0x00 on the same edge.
- `ena`=0 only blocks the IDLE→EXEC transition. A transaction already in progress completes normally.
- Reserved bits `ui_in[5:3]` have no effect.
- Reset asserted mid-transaction returns everything to reset values immediately (asynchronously). A write whose EXEC edge has not occurred is lost.

## Timing
- Let N be the first rising edge that samples `req`=1.
  - With `SYNC_STAGES`=2, `req_s`=1 after edge N+1.
  - EXEC is entered at edge N+2.
  - ACK is entered, and ack becomes visible, after edge N+3.
- Latency from req to ack is 4 edges. Each extra sync stage adds 1 edge.
- Read data is valid in the same cycle that ack rises, and is held for the whole of ACK.
- Let M be the first edge that samples `req`=0 while in ACK. Ack falls after edge M+`SYNC_STAGES`.
- The minimum ack width is 1 cycle. This case occurs when `req` dropped during sync or EXEC.
- Back-to-back transactions: the next req rise is accepted only after IDLE is re-entered, so there is no overlap.

## Structure
- Package `host_pin_pkg`:
  - state enum `{IDLE, EXEC, ACK}`.
  - pin bit-index constants: `REQ_BIT`=7, `WE_BIT`=6, `ADDR_LSB`=0, `ADDR_W`=3, `ACK_BIT`=7.
  - `ADDR_COUNTER`=3'd7, `NUM_RW_REGS`=7.
- Sub-module `sync_ff`: a parameterised `SYNC_STAGES` flop chain with async active-low reset to 0. It is reused for any future asynchronous pin input.

## Test plan
- Reset: after `rst_n` low then high, check `uo_out`=0x00, `uio_out`=0x00 and `uio_oe`=0x00. Then read addrs 0–7; all return 0x00.
- Write then read:
  - Write addr 3 with data 0xA5. Check that ack rises exactly 4 edges after req is sampled.
  - Read addr 3 → `uio_out`=0xA5 and `uio_oe`=0xFF during ack.
  - `uo_out[6:4]`=3 and `uo_out[3:0]`=2.
- Counter register: after 5 transactions, write 0x55 to addr 7. Ack is returned, then read addr 7 → 0x06 (the discarded write still counted). After 256 transactions from reset, counter = 0x00.
- `ena`=0: assert req with `ena`=0 for 20 cycles → ack stays 0 and the counter is unchanged. Raise `ena` → ack follows 1 cycle later, once IDLE→EXEC fires.
- Early req drop: pulse req for 1 cycle → the transaction still completes, ack is high for exactly 1 cycle, and the write is committed.
- Reset in ACK: assert `rst_n` low while a read is in ACK → ack, `uio_oe` and `uio_out` go 0 without waiting for a clock edge, and regs return to 0x00.

Source files
------------

// File: rtl/host_pin_responder_pkg.sv
// Shared types and pin-map constants for the host pin responder.
package host_pin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int unsigned PIN_W       = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned REQ_BIT     = 7;
  localparam int unsigned WE_BIT      = 6;
  localparam int unsigned ADDR_LSB    = 0;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned ACK_BIT     = 7;
  localparam int unsigned NUM_RW_REGS = 7;

  localparam logic [ADDR_W-1:0] ADDR_COUNTER = 3'd7;

  // Command latched from the pins when a transaction is accepted.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } host_cmd_t;

endpackage

// File: rtl/host_pin_responder_if.sv
// Top-level pin bundle between the host side and the responder.
interface host_pin_if
  import host_pin_pkg::*;
;
  logic             ena;
  logic [PIN_W-1:0] ui_in;
  logic [PIN_W-1:0] uio_in;
  logic [PIN_W-1:0] uo_out;
  logic [PIN_W-1:0] uio_out;
  logic [PIN_W-1:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/host_pin_responder_sync_ff.sv
// Generic flop-chain synchronizer for asynchronous single-bit pin inputs.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the input through the chain; the last stage is the safe copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= {chain_q[SYNC_STAGES-2:0], d};
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/host_pin_responder.sv
// Register-file responder: req/ack host transactions over the top-level pins.
module host_pin_responder
  import host_pin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  host_pin_if.slave  pins
);

  state_e            state_q, state_d;
  logic              req_s;
  logic              capture_c, commit_c, release_c;
  host_cmd_t         cmd_q;
  logic [DATA_W-1:0] regs_q [NUM_RW_REGS];
  logic [DATA_W-1:0] counter_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              ack_q;
  logic [PIN_W-1:0]  oe_q;
  logic [DATA_W-1:0] rdout_q;
  logic [DATA_W-1:0] rd_val_c;
  logic              unused_rsvd;

  // Reserved command bits are deliberately ignored.
  assign unused_rsvd = ^pins.ui_in[5:3];

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins.ui_in[REQ_BIT]),
    .q     (req_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-edge strobes; EXEC is committed regardless of req.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    release_c = 1'b0;
    case (state_q)
      IDLE: if (req_s && pins.ena) begin
        state_d   = EXEC;
        capture_c = 1'b1;
      end
      EXEC: begin
        state_d  = ACK;
        commit_c = 1'b1;
      end
      ACK: if (!req_s) begin
        state_d   = IDLE;
        release_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read source: general register, or the transaction counter at addr 7.
  always_comb begin
    rd_val_c = counter_q;
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (cmd_q.addr == ADDR_W'(i)) rd_val_c = regs_q[i];
    end
  end

  // Command capture, register commit, counter and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      counter_q   <= '0;
      last_addr_q <= '0;
      ack_q       <= 1'b0;
      oe_q        <= '0;
      rdout_q     <= '0;
      for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (capture_c) begin
        cmd_q.we   <= pins.ui_in[WE_BIT];
        cmd_q.addr <= pins.ui_in[ADDR_LSB +: ADDR_W];
        cmd_q.data <= pins.uio_in;
      end
      if (commit_c) begin
        if (cmd_q.we) begin
          for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (cmd_q.addr == ADDR_W'(i)) regs_q[i] <= cmd_q.data;
          end
        end
        counter_q   <= counter_q + DATA_W'(1);
        last_addr_q <= cmd_q.addr;
        ack_q       <= 1'b1;
        oe_q        <= cmd_q.we ? '0 : '1;
        rdout_q     <= cmd_q.we ? '0 : rd_val_c;
      end
      if (release_c) begin
        ack_q   <= 1'b0;
        oe_q    <= '0;
        rdout_q <= '0;
      end
    end
  end

  assign pins.uo_out  = {ack_q, last_addr_q, counter_q[3:0]};
  assign pins.uio_out = rdout_q;
  assign pins.uio_oe  = oe_q;

endmodule

// File: tb/tb_host_pin_responder.sv
// Directed bench for host_pin_responder: handshake timing, registers, counter.
module tb_host_pin_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  host_pin_if pins ();

  host_pin_responder #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins.slave)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    pins.ena    = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full handshake; reports what was seen during ack and edge counts.
  task automatic xact(input logic we, input logic [2:0] addr, input logic [7:0] data,
                      output logic [7:0] rdata, output logic [7:0] oe, output logic [7:0] uo,
                      output int rise_edges, output int fall_edges);
    rise_edges = 0;
    fall_edges = 0;
    rdata = 8'hxx; oe = 8'hxx; uo = 8'hxx;
    @(negedge clk);
    pins.ui_in  = {1'b1, we, 3'b000, addr};
    pins.uio_in = data;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      rise_edges++;
      if (pins.uo_out[7]) break;
    end
    if (!pins.uo_out[7]) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout addr=%0d: ack never rose", addr);
    end
    rdata = pins.uio_out;
    oe    = pins.uio_oe;
    uo    = pins.uo_out;
    @(negedge clk);
    pins.ui_in = 8'h00;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      fall_edges++;
      if (!pins.uo_out[7]) break;
    end
    if (pins.uo_out[7]) begin
      n_checks++; n_fail++;
      $display("FAIL ack_fall_timeout addr=%0d: ack never fell", addr);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd, oe, uo;
    int re, fe;
    logic [2:0] a;
    do_reset();
    #1;
    n_checks++; if (pins.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out got=%h exp=00", pins.uo_out); end
    n_checks++; if (pins.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out got=%h exp=00", pins.uio_out); end
    n_checks++; if (pins.uio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_uio_oe got=%h exp=00", pins.uio_oe); end
    // Counter first (still zero), then the general registers.
    for (int i = 0; i < 8; i++) begin
      a = 3'((i + 7) % 8);
      xact(1'b0, a, 8'h00, rd, oe, uo, re, fe);
      n_checks++;
      if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=00", a, rd); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd, oe, uo;
    int re, fe;
    do_reset();
    xact(1'b1, 3'd3, 8'hA5, rd, oe, uo, re, fe);
    n_checks++; if (re !== 4) begin n_fail++; $display("FAIL wr_ack_latency got=%0d exp=4", re); end
    n_checks++; if (fe !== 3) begin n_fail++; $display("FAIL wr_ack_fall got=%0d exp=3", fe); end
    n_checks++; if (oe !== 8'h00 || rd !== 8'h00) begin n_fail++; $display("FAIL wr_bus_idle oe=%h out=%h exp=00/00", oe, rd); end
    xact(1'b0, 3'd3, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data got=%h exp=a5", rd); end
    n_checks++; if (oe !== 8'hFF) begin n_fail++; $display("FAIL rd_oe got=%h exp=ff", oe); end
    n_checks++; if (uo !== 8'h B2) begin n_fail++; $display("FAIL rd_uo_out got=%h exp=b2", uo); end
  endtask

  task automatic test_counter();
    logic [7:0] rd, oe, uo;
    int re, fe;
    do_reset();
    for (int i = 0; i < 5; i++) xact(1'b1, 3'(i), 8'(8'h10 + i), rd, oe, uo, re, fe);
    xact(1'b1, 3'd7, 8'h55, rd, oe, uo, re, fe);
    n_checks++; if (uo !== 8'hF6) begin n_fail++; $display("FAIL cnt_wr7_uo got=%h exp=f6", uo); end
    xact(1'b0, 3'd7, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'h06) begin n_fail++; $display("FAIL cnt_read7 got=%h exp=06", rd); end
    xact(1'b0, 3'd4, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'h14) begin n_fail++; $display("FAIL cnt_reg4 got=%h exp=14", rd); end
    do_reset();
    for (int i = 0; i < 255; i++) xact(1'b1, 3'd1, 8'(i), rd, oe, uo, re, fe);
    n_checks++; if (uo[3:0] !== 4'hF) begin n_fail++; $display("FAIL cnt_255 got=%h exp=f", uo[3:0]); end
    xact(1'b0, 3'd7, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL cnt_read_ff got=%h exp=ff", rd); end
    n_checks++; if (uo[3:0] !== 4'h0) begin n_fail++; $display("FAIL cnt_wrap_nibble got=%h exp=0", uo[3:0]); end
    xact(1'b0, 3'd7, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL cnt_wrap_read got=%h exp=00", rd); end
  endtask

  task automatic test_ena();
    int ack_seen = 0;
    logic ack_e, ack_e1;
    logic [7:0] rd_e1, cnt_e1;
    do_reset();
    @(negedge clk);
    pins.ena   = 1'b0;
    pins.ui_in = 8'h87;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pins.uo_out[7]) ack_seen++;
    end
    n_checks++; if (ack_seen !== 0) begin n_fail++; $display("FAIL ena_block ack_cycles=%0d exp=0", ack_seen); end
    n_checks++; if (pins.uo_out[3:0] !== 4'h0) begin n_fail++; $display("FAIL ena_counter got=%h exp=0", pins.uo_out[3:0]); end
    @(negedge clk);
    pins.ena = 1'b1;
    @(posedge clk); #1; ack_e = pins.uo_out[7];
    @(posedge clk); #1; ack_e1 = pins.uo_out[7]; rd_e1 = pins.uio_out; cnt_e1 = {4'h0, pins.uo_out[3:0]};
    n_checks++; if (ack_e !== 1'b0 || ack_e1 !== 1'b1) begin n_fail++; $display("FAIL ena_release ack=%b%b exp=01", ack_e, ack_e1); end
    n_checks++; if (rd_e1 !== 8'h00 || cnt_e1 !== 8'h01) begin n_fail++; $display("FAIL ena_read data=%h cnt=%h exp=00/01", rd_e1, cnt_e1); end
    @(negedge clk);
    pins.ui_in = 8'h00;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_early_drop();
    int first = 0, width = 0;
    logic [7:0] rd, oe, uo;
    int re, fe;
    do_reset();
    @(negedge clk);
    pins.ui_in  = 8'hC5;
    pins.uio_in = 8'h3C;
    @(negedge clk);
    pins.ui_in = 8'h45;
    for (int i = 2; i <= 12; i++) begin
      @(posedge clk); #1;
      if (pins.uo_out[7]) begin
        width++;
        if (first == 0) first = i;
      end
    end
    n_checks++; if (width !== 1) begin n_fail++; $display("FAIL early_ack_width got=%0d exp=1", width); end
    n_checks++; if (first !== 4) begin n_fail++; $display("FAIL early_ack_edge got=%0d exp=4", first); end
    pins.ui_in = 8'h00;
    xact(1'b0, 3'd5, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL early_commit got=%h exp=3c", rd); end
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] rd, oe, uo;
    int re, fe;
    do_reset();
    xact(1'b1, 3'd2, 8'h77, rd, oe, uo, re, fe);
    @(negedge clk);
    pins.ui_in = 8'h82;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (pins.uo_out[7]) break;
    end
    n_checks++; if (pins.uio_out !== 8'h77 || pins.uio_oe !== 8'hFF) begin n_fail++; $display("FAIL rst_ack_pre out=%h oe=%h exp=77/ff", pins.uio_out, pins.uio_oe); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pins.uo_out !== 8'h00 || pins.uio_out !== 8'h00 || pins.uio_oe !== 8'h00) begin
      n_fail++; $display("FAIL rst_async uo=%h out=%h oe=%h exp=00/00/00", pins.uo_out, pins.uio_out, pins.uio_oe);
    end
    pins.ui_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 3'd2, 8'h00, rd, oe, uo, re, fe);
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_reg_cleared got=%h exp=00", rd); end
  endtask

  initial begin
    rst_n       = 1'b0;
    pins.ena    = 1'b0;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    test_reset();
    test_write_read();
    test_counter();
    test_ena();
    test_early_drop();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
